// File: rtl/filter_pkg.sv
// Shared FSM state type and frame-shape constants for the sample transmitter.
package filter_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
endpackage

// File: rtl/filter_sample_fifo.sv
// Synchronous FIFO with a combinational head read; push when full and pop when empty are ignored.
module filter_sample_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/filter_sample_tx.sv
// Buffers filter samples and shifts them out as UART frames (start, 8 data LSB first, stop).
// Define FILTER_SAMPLE_TX_PARITY_EN to add an even-parity bit between data and stop.
module filter_sample_tx
  import filter_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);
  localparam logic [15:0]   BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0]   STOP_LAST = 16'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);

  tx_state_t     state;
  logic [15:0]   timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic [7:0]    head;
  logic          push, pop, full, empty, bit_done;
  logic [CW-1:0] count_next;
`ifdef FILTER_SAMPLE_TX_PARITY_EN
  logic          par;
`endif

  assign push     = s_valid & s_ready & ~full;
  assign bit_done = (timer == '0);
  // The head is consumed when a new frame starts: from IDLE, or straight out of the stop bit.
  assign pop      = ~empty & ((state == IDLE) | ((state == STOP) & bit_done));

  always_comb count_next = fifo_count + CW'(push) - CW'(pop);

  filter_sample_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (s_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Ready reflects occupancy after this edge, so a pop never raises it in its own cycle.
  always_ff @(posedge clk) begin
    if (reset) s_ready <= 1'b0;
    else       s_ready <= (count_next != FULL_CNT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      timer   <= '0;
      bit_idx <= '0;
      shreg   <= '0;
`ifdef FILTER_SAMPLE_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (pop) begin
      state <= START;
      tx    <= 1'b0;
      busy  <= 1'b1;
      timer <= BIT_LAST;
      shreg <= head;
`ifdef FILTER_SAMPLE_TX_PARITY_EN
      par   <= ^head;
`endif
    end else begin
      timer <= timer - 1'b1;
      case (state)
        START: if (bit_done) begin
          state   <= DATA;
          tx      <= shreg[0];
          timer   <= BIT_LAST;
          bit_idx <= '0;
        end
        DATA: if (bit_done) begin
          timer <= BIT_LAST;
          if (bit_idx == LAST_BIT) begin
`ifdef FILTER_SAMPLE_TX_PARITY_EN
            state <= PARITY;
            tx    <= par;
`else
            state <= STOP;
            tx    <= 1'b1;
            timer <= STOP_LAST;
`endif
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
          end
        end
`ifdef FILTER_SAMPLE_TX_PARITY_EN
        PARITY: if (bit_done) begin
          state <= STOP;
          tx    <= 1'b1;
          timer <= STOP_LAST;
        end
`endif
        STOP: if (bit_done) begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
